sub_serial: RTL and testbench
=============================

Name: sub_serial

Overview:
- Bit-serial subtractor; inverse-operation counterpart of the team's bit-serial adder.
- Captures two parallel W-bit operands on a start request, then computes a - b LSB-first, one bit per clock, through a borrow flip-flop.
- Delivers the parallel difference, a final borrow and a done flag.
- Used where area matters more than latency, alongside the serial adder in the datapath.

Parameters:
- W, 8, operand/result width in bits (W >= 2).
- CW, 3, counter width; must satisfy 2^CW >= W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  start request; sampled only in IDLE.
- a  input  W  minuend; sampled only on the start edge.
- b  input  W  subtrahend; sampled only on the start edge.
- diff  output  W  difference a - b mod 2^W; valid while done=1.
- borrow  output  1  final borrow; 1 iff a < b unsigned; valid while done=1.
- busy  output  1  high while state is SUB.
- done  output  1  high while state is DONE.

Behaviour:
- Reset: rst=1 immediately forces the following, regardless of clk or any operation in progress:
  - state=IDLE.
  - a_reg, b_reg, diff, count=0.
  - brw=0, borrow=0, busy=0, done=0.
- State machine: IDLE=0, SUB=1, DONE=2. Encoding 3 is illegal and returns to IDLE on the next edge.
- IDLE:
  - If en=1: a_reg<=a, b_reg<=b, diff<=0, count<=0, brw<=0; go to SUB.
  - Else: hold all registers (diff and borrow keep their last values).
- SUB, every edge:
  - d = a_reg[0]^b_reg[0]^brw.
  - brw <= (~a_reg[0]&b_reg[0]) | (~a_reg[0]&brw) | (b_reg[0]&brw).
  - diff <= {d, diff[W-1:1]}.
  - a_reg <= a_reg>>1, b_reg <= b_reg>>1, count <= count+1.
  - When count==W-1: go to DONE and load borrow with the brw-next value.
- SUB ignores en, a and b. Operand changes mid-operation do not affect the result.
- DONE: hold diff and borrow. If en=0, go to IDLE; if en=1, stay in DONE. Exactly one operation runs per en assertion; en held high does not retrigger.
- busy and done are registered, decoded from next-state: they change on the same edge the state changes.
- Latency: start edge E0 (en=1 in IDLE), then SUB edges E1..EW. done rises at EW, i.e. W cycles after E0 (8 for W=8).
- The earliest next start edge is one cycle after en falls in DONE (DONE->IDLE, then IDLE sees en=1).
- Wrap-around: diff is modulo 2^W. Examples: 0x00-0x01 gives 0xFF with borrow=1; a==b gives 0 with borrow=0.
- Reset mid-operation aborts the operation. No partial result is retained.

Optional Feature:
- Macro: SUB_SERIAL_OVF_EN.
- Defined:
  - Adds output port ovf (output, 1 bit): two's-complement signed overflow of a - b.
  - ovf = (a_reg_orig[W-1]!=b_reg_orig[W-1]) && (d_at_count_W-1 != a_reg_orig[W-1]).
  - Loaded on the SUB->DONE edge. Requires sign bits of a and b captured at start into dedicated flops.
  - Reset value 0; held until the next completion.
- Undefined: ovf port and the sign flops are absent. All other behaviour is identical.

Test Plan:
- a=0x3C, b=0x15, en pulse in IDLE -> busy=1 for 8 cycles; done=1 at E8 with diff=0x27, borrow=0.
- a=0x05, b=0x0A -> diff=0xFB, borrow=1. Then a=0xFF, b=0x01 -> diff=0xFE, borrow=0. Then a=b=0x00 -> diff=0x00, borrow=0.
- en held high across completion -> state stays DONE and diff is stable. Drop en -> IDLE next edge. Re-raise en -> new operation starts.
- Start with a=0x10, b=0x01; during SUB drive a=0xFF, b=0xFF and toggle en -> result diff=0x0F, borrow=0, done still at E8.
- Assert rst asynchronously during the 4th SUB cycle -> diff=0, borrow=0, busy=0, done=0, state IDLE. A following a=0x80, b=0x80 op gives diff=0x00, borrow=0.
- With SUB_SERIAL_OVF_EN:
  - a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1.
  - a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
  - a=0x10, b=0x05 -> ovf=0.

Source files
------------

// File: rtl/sub_serial_if.sv
// Handshake/result bundle for the bit-serial subtractor.
// With SUB_SERIAL_OVF_EN defined, the bundle also carries the signed-overflow flag ovf.
interface sub_serial_if #(
    parameter int W = 8
);
    logic         en;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         busy;
    logic         done;
`ifdef SUB_SERIAL_OVF_EN
    logic         ovf;

    modport master (output en, a, b, input diff, borrow, busy, done, ovf);
    modport slave  (input en, a, b, output diff, borrow, busy, done, ovf);
`else
    modport master (output en, a, b, input diff, borrow, busy, done);
    modport slave  (input en, a, b, output diff, borrow, busy, done);
`endif
endinterface

// File: rtl/sub_serial.sv
// Bit-serial subtractor: captures a and b, then produces a - b LSB-first through a borrow flop.
// Optional macro SUB_SERIAL_OVF_EN adds a registered two's-complement overflow output.
module sub_serial #(
    parameter int W  = 8,
    parameter int CW = 3
) (
    input  logic        clk,
    input  logic        rst,
    sub_serial_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  diff_q, diff_d;
    logic [CW-1:0] count_q, count_d;
    logic          brw_q, brw_d;
    logic          borrow_q, borrow_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          d_bit;
    logic          brw_nxt;
`ifdef SUB_SERIAL_OVF_EN
    logic          sa_q, sa_d;
    logic          sb_q, sb_d;
    logic          ovf_q, ovf_d;
`endif

    // One full-subtractor slice on the current LSBs.
    assign d_bit   = a_q[0] ^ b_q[0] ^ brw_q;
    assign brw_nxt = (~a_q[0] & b_q[0]) | (~a_q[0] & brw_q) | (b_q[0] & brw_q);

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        count_d  = count_q;
        brw_d    = brw_q;
        borrow_d = borrow_q;
`ifdef SUB_SERIAL_OVF_EN
        sa_d     = sa_q;
        sb_d     = sb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    diff_d  = {W{1'b0}};
                    count_d = {CW{1'b0}};
                    brw_d   = 1'b0;
`ifdef SUB_SERIAL_OVF_EN
                    sa_d    = bus.a[W-1];
                    sb_d    = bus.b[W-1];
`endif
                    state_d = SUB;
                end else begin
                    state_d = IDLE;
                end
            end
            SUB: begin
                diff_d  = {d_bit, diff_q[W-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                brw_d   = brw_nxt;
                count_d = count_q + CW'(1);
                if (count_q == CW'(W - 1)) begin
                    state_d  = DONE;
                    borrow_d = brw_nxt;
`ifdef SUB_SERIAL_OVF_EN
                    // Overflow only when signs differ and the result sign departs from a's.
                    ovf_d    = (sa_q != sb_q) && (d_bit != sa_q);
`endif
                end else begin
                    state_d = SUB;
                end
            end
            DONE: begin
                if (bus.en) begin
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SUB);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            diff_q   <= {W{1'b0}};
            count_q  <= {CW{1'b0}};
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            count_q  <= count_d;
            brw_q    <= brw_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SUB_SERIAL_OVF_EN
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
`ifdef SUB_SERIAL_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Randomized scoreboard bench for sub_serial; reference results come from plain integer subtraction.
// Overflow is checked only when SUB_SERIAL_OVF_EN is defined.
module tb_sub_serial;
    localparam int W   = 8;
    localparam int CW  = 3;
    localparam int PER = 10;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        time          t0;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    sub_serial_if #(.W(W)) bif ();

    sub_serial #(.W(W), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #(PER / 2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa;
        int   sb;
        int   r;
        sa       = int'($signed(a));
        sb       = int'($signed(b));
        r        = sa - sb;
        e.diff   = W'((int'(a) - int'(b) + (1 << W)) % (1 << W));
        e.borrow = (int'(a) < int'(b));
        e.ovf    = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
        e.t0     = 0;
        return e;
    endfunction

    // Monitor: pops the scoreboard on each done rise, and measures busy pulse length.
    task automatic monitor();
        logic done_prev;
        int   bcnt;
        exp_t e;
        done_prev = 1'b0;
        bcnt      = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0;
                bcnt      = 0;
            end else begin
                if (bif.done && !done_prev) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", sb_q.size(), 1);
                    end else begin
                        e = sb_q.pop_front();
                        check("diff", bif.diff, e.diff);
                        check("borrow", bif.borrow, e.borrow);
                        check("latency", 32'($time - e.t0), W * PER + PER / 2);
`ifdef SUB_SERIAL_OVF_EN
                        check("ovf", bif.ovf, e.ovf);
`endif
                    end
                end
                if (bif.busy) begin
                    bcnt++;
                end else if (bcnt != 0) begin
                    check("busy_len", bcnt, W);
                    bcnt = 0;
                end
                done_prev = bif.done;
            end
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold, input bit scramble);
        exp_t e;
        bit   got;
        e = model(a, b);
        @(negedge clk);
        bif.en = 1'b1;
        bif.a  = a;
        bif.b  = b;
        @(posedge clk);
        e.t0 = $time;
        sb_q.push_back(e);
        #1;
        if (!hold) bif.en = 1'b0;
        got = 1'b0;
        for (int i = 0; i < W + 4 && !got; i++) begin
            @(negedge clk);
            if (bif.done) begin
                got = 1'b1;
            end else if (scramble) begin
                bif.en = 1'($urandom);
                bif.a  = W'($urandom);
                bif.b  = W'($urandom);
            end
        end
        if (!got) begin
            check("done_timeout", bif.done, 1);
            sb_q.delete();
        end
        if (hold) begin
            bif.en = 1'b1;
            repeat (3) begin
                @(negedge clk);
                check("hold_done", bif.done, 1);
                check("hold_diff", bif.diff, e.diff);
            end
        end
        bif.en = 1'b0;
        @(negedge clk);
        check("done_clear", bif.done, 0);
        check("idle_busy", bif.busy, 0);
    endtask

    initial begin
        rst    = 1'b1;
        bif.en = 1'b0;
        bif.a  = '0;
        bif.b  = '0;
        checks = 0;
        errors = 0;
        fork
            monitor();
        join_none
        @(negedge clk);
        check("rst_diff", bif.diff, 0);
        check("rst_borrow", bif.borrow, 0);
        check("rst_busy", bif.busy, 0);
        check("rst_done", bif.done, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(8'h3C, 8'h15, 1'b0, 1'b0);
        do_op(8'h05, 8'h0A, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'h00, 8'h00, 1'b0, 1'b0);
        do_op(8'h00, 8'h01, 1'b0, 1'b0);
        do_op(8'hA5, 8'hA5, 1'b1, 1'b0);
        do_op(8'h10, 8'h01, 1'b0, 1'b1);

        // Abort an operation with reset during the fourth SUB cycle.
        @(negedge clk);
        bif.en = 1'b1;
        bif.a  = 8'hFF;
        bif.b  = 8'h00;
        @(posedge clk);
        #1 bif.en = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_diff", bif.diff, 0);
        check("abort_borrow", bif.borrow, 0);
        check("abort_busy", bif.busy, 0);
        check("abort_done", bif.done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_op(8'h80, 8'h80, 1'b0, 1'b0);

        do_op(8'h80, 8'h01, 1'b0, 1'b0);
        do_op(8'h7F, 8'hFF, 1'b0, 1'b0);
        do_op(8'h10, 8'h05, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            do_op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(PER * 50000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
